wm8731_i2c_scheduler: RTL and testbench
=======================================

Name: wm8731_i2c_scheduler

Overview:
Shares the single 16-bit-word I2C master between two requesters: the boot-time WM8731 register sequencer (port 0) and the runtime control path, e.g. headphone volume or mute updates (port 1). It arbitrates, launches one I2C write per accepted word, and waits for completion with a timeout. It retries on NACK or timeout, reports per-transaction status, and enforces an idle guard gap between transactions.

Parameters:
DATA_W, 16, width of one WM8731 command word ({reg[6:0], data[8:0]})
TIMEOUT_CYC, 50000, max cycles in WAIT before a timeout (1 ms at 50 MHz)
MAX_RETRY, 2, reissues allowed after the first attempt fails
GAP_CYC, 100, idle cycles enforced between I2C transactions; 0 is legal
STARVE_LIM, 4, consecutive port-0 grants with port 1 pending before port 1 is forced a grant

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset
req0_valid  in  1  port 0 (config sequencer) has a word
req0_data  in  DATA_W  port 0 command word
req0_ready  out  1  port 0 word accepted this cycle when valid
req1_valid  in  1  port 1 (runtime control) has a word
req1_data  in  DATA_W  port 1 command word
req1_ready  out  1  port 1 word accepted this cycle when valid
m_start  out  1  one-cycle start pulse to the I2C master
m_data  out  DATA_W  word to the I2C master; held stable from ISSUE through the end of WAIT
m_done  in  1  one-cycle completion pulse from the I2C master
m_nack  in  1  qualified by m_done; 1 = slave NACK
busy  out  1  state != IDLE
rsp_valid  out  1  one-cycle status pulse per accepted word
rsp_id  out  1  port that owned the finished word
rsp_ok  out  1  1 = written with ACK; 0 = retries exhausted

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; m_start, m_data, rsp_valid, rsp_id, rsp_ok, busy, retry_cnt, starve_cnt, timer all 0.
  - req0_ready and req1_ready are forced 0 while reset is low.
  - An in-flight transfer is abandoned, not reported. The I2C master shares this reset.
- States: IDLE, ISSUE, WAIT, RESP, GAP.
- IDLE:
  - reqX_ready is combinational: (state==IDLE) && winner==X.
  - Winner selection:
    - Port 0 wins by default.
    - Port 1 wins when only req1_valid is high.
    - Port 1 also wins when both are valid and starve_cnt==STARVE_LIM.
  - On the accept edge:
    - Latch data into m_data and the owner id; retry_cnt=0; go to ISSUE.
    - starve_cnt: +1 when port 0 wins while req1_valid=1; cleared when port 1 wins or req1_valid=0. Saturates at STARVE_LIM.
  - Neither valid: stay in IDLE, ready low.
- ISSUE: m_start=1 for exactly this one cycle; timer=0; go to WAIT.
- WAIT:
  - timer increments each cycle.
  - m_done && !m_nack: success, go to RESP with ok=1.
  - m_done && m_nack, or timer==TIMEOUT_CYC-1 without m_done: failure.
    - retry_cnt<MAX_RETRY: retry_cnt+1, go to GAP and then back to ISSUE with the same m_data. No rsp is emitted.
    - Otherwise: go to RESP with ok=0.
  - m_done coincident with timeout expiry: m_done wins.
- RESP: rsp_valid=1 for one cycle with rsp_id and rsp_ok; go to GAP.
- GAP:
  - Hold for GAP_CYC cycles. GAP_CYC=0 passes straight through.
  - Exit to ISSUE on the retry path, otherwise to IDLE.
- m_done in any state other than WAIT is ignored.
- m_start is never asserted outside ISSUE.
- Latency:
  - Accept edge to m_start: 1 cycle.
  - m_done to rsp_valid: 1 cycle.
  - Earliest next accept after rsp_valid: GAP_CYC+1 cycles.
- Requester data is not sampled after the accept edge; the requester may change it freely afterwards.
- Counter widths: $clog2 of each limit + 1. No wrap is possible before the compare.

Test Plan:
- Single port-0 word 16'h0C00, m_done/ack 40 cycles after m_start -> req0_ready high 1 cycle; m_start exactly 1 cycle later with m_data=16'h0C00; rsp_valid 1 cycle after m_done with id=0, ok=1; busy low GAP_CYC+1 cycles after rsp_valid.
- Both ports valid on the same cycle, word A on port 0 and word B on port 1 -> A granted first, B granted after A's GAP; rsp order id=0 then id=1; no overlapping m_start.
- Port 0 held valid for 10 words, port 1 valid throughout -> port 1 granted as the 5th grant (after 4 port-0 grants); then port 0 resumes; starve_cnt cleared.
- NACK on every attempt, MAX_RETRY=2 -> 3 m_start pulses, each separated by ≥GAP_CYC idle cycles, identical m_data; a single rsp_valid with ok=0.
- m_done never returned, TIMEOUT_CYC=50 -> retry after 50 WAIT cycles; after the third timeout rsp ok=0. A second run with m_done coinciding with the 50th WAIT cycle -> ok=1, no retry.
- Reset pulled low in WAIT -> all outputs 0 immediately (asynchronously); after release, a new word is accepted normally with no stale rsp.

Source files
------------

// File: rtl/wm8731_i2c_scheduler_if.sv
// Bundle of the requester handshakes, the I2C-master command/completion pair
// and the per-transaction status outputs of the WM8731 I2C scheduler.
// The scheduler uses the master view; requesters, the I2C master model and
// the status consumer use the slave view.
`timescale 1ns/1ps
interface wm8731_i2c_scheduler_if #(
  parameter int DATA_W = 16
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              m_start;
  logic [DATA_W-1:0] m_data;
  logic              m_done;
  logic              m_nack;
  logic              busy;
  logic              rsp_valid;
  logic              rsp_id;
  logic              rsp_ok;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, m_done, m_nack,
    output req0_ready, req1_ready, m_start, m_data, busy,
           rsp_valid, rsp_id, rsp_ok
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, m_done, m_nack,
    input  req0_ready, req1_ready, m_start, m_data, busy,
           rsp_valid, rsp_id, rsp_ok
  );
endinterface

// File: rtl/wm8731_i2c_scheduler.sv
// Two-port scheduler in front of one 16-bit-word I2C master for the WM8731.
// Port 0 (boot sequencer) wins by default, port 1 (runtime control) wins when
// alone or after STARVE_LIM consecutive port-0 grants it sat through.
// Each word is issued, awaited with a timeout, retried up to MAX_RETRY times,
// reported once on rsp_*, and followed by a GAP_CYC idle guard.
`timescale 1ns/1ps
module wm8731_i2c_scheduler #(
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 50000,
  parameter int MAX_RETRY   = 2,
  parameter int GAP_CYC     = 100,
  parameter int STARVE_LIM  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  wm8731_i2c_scheduler_if.master        bus
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
  localparam int RTY_W = $clog2(MAX_RETRY) + 1;
  localparam int GAP_W = $clog2(GAP_CYC) + 1;
  localparam int STV_W = $clog2(STARVE_LIM) + 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, GAP} state_t;

  state_t            state_r, next_state_s;
  logic [TMR_W-1:0]  timer_r;
  logic [RTY_W-1:0]  retry_r;
  logic [GAP_W-1:0]  gap_r;
  logic [STV_W-1:0]  starve_r;
  logic              retry_pend_r;
  logic              owner_r;
  logic [DATA_W-1:0] m_data_r;
  logic              m_start_r, busy_r, rsp_valid_r, rsp_id_r, rsp_ok_r;
  logic              p1_win_s, accept_s, ok_s, retry_s;

  // Winner selection, next state and per-transition qualifiers.
  always_comb begin
    next_state_s = state_r;
    p1_win_s     = 1'b0;
    accept_s     = 1'b0;
    ok_s         = 1'b0;
    retry_s      = 1'b0;
    if (bus.req1_valid && (!bus.req0_valid || starve_r == STV_W'(STARVE_LIM))) begin
      p1_win_s = 1'b1;
    end else begin
      p1_win_s = 1'b0;
    end
    case (state_r)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          accept_s     = 1'b1;
          next_state_s = ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: next_state_s = WAIT;
      WAIT: begin
        // A completion in the expiry cycle takes precedence over the timeout.
        if (bus.m_done && !bus.m_nack) begin
          ok_s         = 1'b1;
          next_state_s = RESP;
        end else if (bus.m_done || timer_r == TMR_W'(TIMEOUT_CYC - 1)) begin
          if (retry_r < RTY_W'(MAX_RETRY)) begin
            retry_s = 1'b1;
            if (GAP_CYC == 0) begin
              next_state_s = ISSUE;
            end else begin
              next_state_s = GAP;
            end
          end else begin
            next_state_s = RESP;
          end
        end else begin
          next_state_s = WAIT;
        end
      end
      RESP: begin
        if (GAP_CYC == 0) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = GAP;
        end
      end
      GAP: begin
        if (gap_r == GAP_W'(GAP_CYC - 1)) begin
          next_state_s = retry_pend_r ? ISSUE : IDLE;
        end else begin
          next_state_s = GAP;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Ready is combinational in IDLE and forced low while reset is held.
  assign bus.req0_ready = reset && (state_r == IDLE) && bus.req0_valid && !p1_win_s;
  assign bus.req1_ready = reset && (state_r == IDLE) && p1_win_s;

  assign bus.m_start   = m_start_r;
  assign bus.m_data    = m_data_r;
  assign bus.busy      = busy_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_ok    = rsp_ok_r;

  // State, counters and registered outputs; reset abandons any transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      timer_r      <= '0;
      retry_r      <= '0;
      gap_r        <= '0;
      starve_r     <= '0;
      retry_pend_r <= 1'b0;
      owner_r      <= 1'b0;
      m_data_r     <= '0;
      m_start_r    <= 1'b0;
      busy_r       <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_ok_r     <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      m_start_r   <= (next_state_s == ISSUE);
      busy_r      <= (next_state_s != IDLE);
      rsp_valid_r <= (next_state_s == RESP);

      if (accept_s) begin
        m_data_r <= p1_win_s ? bus.req1_data : bus.req0_data;
        owner_r  <= p1_win_s;
        retry_r  <= '0;
        if (p1_win_s || !bus.req1_valid) begin
          starve_r <= '0;
        end else if (starve_r != STV_W'(STARVE_LIM)) begin
          starve_r <= starve_r + STV_W'(1);
        end else begin
          starve_r <= starve_r;
        end
      end else if (retry_s) begin
        retry_r <= retry_r + RTY_W'(1);
      end else begin
        retry_r <= retry_r;
      end

      if (retry_s) begin
        retry_pend_r <= 1'b1;
      end else if (next_state_s == ISSUE) begin
        retry_pend_r <= 1'b0;
      end else begin
        retry_pend_r <= retry_pend_r;
      end

      if (state_r == ISSUE) begin
        timer_r <= '0;
      end else if (state_r == WAIT) begin
        timer_r <= timer_r + TMR_W'(1);
      end else begin
        timer_r <= timer_r;
      end

      if (state_r == GAP) begin
        gap_r <= gap_r + GAP_W'(1);
      end else begin
        gap_r <= '0;
      end

      if (state_r == WAIT && next_state_s == RESP) begin
        rsp_id_r <= owner_r;
        rsp_ok_r <= ok_s;
      end else begin
        rsp_id_r <= rsp_id_r;
        rsp_ok_r <= rsp_ok_r;
      end
    end
  end

endmodule

// File: tb/tb_wm8731_i2c_scheduler.sv
// Self-checking bench for wm8731_i2c_scheduler: a transaction-level model
// predicts every output each cycle, and directed tests pin latencies, grant
// order, retry counts and reset behaviour with hand-computed numbers.
`timescale 1ns/1ps
module tb_wm8731_i2c_scheduler;

  localparam int DW = 16;
  localparam int TO = 50;
  localparam int MR = 2;
  localparam int GC = 5;
  localparam int SL = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wm8731_i2c_scheduler_if #(.DATA_W(DW)) bus();

  wm8731_i2c_scheduler #(
    .DATA_W(DW), .TIMEOUT_CYC(TO), .MAX_RETRY(MR), .GAP_CYC(GC), .STARVE_LIM(SL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit          mdl_idle = 1'b1;
  int          mdl_starve = 0;
  logic        exp_start, exp_busy, exp_rsp_v, exp_rsp_id, exp_rsp_ok;
  logic [15:0] exp_data;

  task automatic clear_exp();
    exp_start = 1'b0; exp_busy = 1'b0; exp_rsp_v = 1'b0;
    exp_rsp_id = 1'b0; exp_rsp_ok = 1'b0; exp_data = 16'h0000;
    mdl_idle = 1'b1; mdl_starve = 0;
  endtask

  task automatic step(output bit abort);
    @(posedge clk or negedge reset);
    abort = !reset;
  endtask

  // One accepted word from grant to return to idle, edge by edge.
  task automatic serve();
    bit ab, p1, ok, failed;
    int attempts;
    attempts = 0;
    p1 = bus.req1_valid && (!bus.req0_valid || mdl_starve == SL);
    if (!p1 && bus.req1_valid) mdl_starve = (mdl_starve < SL) ? mdl_starve + 1 : SL;
    else mdl_starve = 0;
    mdl_idle  = 1'b0;
    exp_busy  = 1'b1;
    exp_data  = p1 ? bus.req1_data : bus.req0_data;
    exp_start = 1'b1;
    forever begin
      step(ab); if (ab) return;
      exp_start = 1'b0;
      ok = 1'b0; failed = 1'b0;
      for (int n = 1; n <= TO; n++) begin
        step(ab); if (ab) return;
        if (bus.m_done === 1'b1) begin
          ok = !bus.m_nack; failed = bus.m_nack;
          break;
        end
        if (n == TO) failed = 1'b1;
      end
      if (failed && attempts < MR) begin
        attempts++;
        for (int g = 0; g < GC; g++) begin
          step(ab); if (ab) return;
        end
        exp_start = 1'b1;
      end else begin
        exp_rsp_v = 1'b1; exp_rsp_id = p1; exp_rsp_ok = ok;
        break;
      end
    end
    step(ab); if (ab) return;
    exp_rsp_v = 1'b0;
    for (int g = 0; g < GC; g++) begin
      step(ab); if (ab) return;
    end
    exp_busy = 1'b0;
    mdl_idle = 1'b1;
  endtask

  initial begin : model
    clear_exp();
    forever begin
      if (!reset) begin
        clear_exp();
        wait (reset === 1'b1);
      end
      @(posedge clk or negedge reset);
      if (reset && mdl_idle && (bus.req0_valid || bus.req1_valid)) serve();
    end
  end

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin : compare
    logic w1, e_r0, e_r1;
    w1   = bus.req1_valid && (!bus.req0_valid || mdl_starve == SL);
    e_r0 = reset && mdl_idle && bus.req0_valid && !w1;
    e_r1 = reset && mdl_idle && w1;
    chk("req0_ready", 32'(bus.req0_ready), 32'(e_r0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(e_r1));
    chk("m_start",    32'(bus.m_start),    32'(exp_start));
    chk("busy",       32'(bus.busy),       32'(exp_busy));
    chk("rsp_valid",  32'(bus.rsp_valid),  32'(exp_rsp_v));
    if (exp_busy || !reset) chk("m_data", 32'(bus.m_data), 32'(exp_data));
    if (exp_rsp_v || !reset) begin
      chk("rsp_id", 32'(bus.rsp_id), 32'(exp_rsp_id));
      chk("rsp_ok", 32'(bus.rsp_ok), 32'(exp_rsp_ok));
    end
  end

  // ---------------- event recorder ----------------
  int          cyc = 0;
  int          grant_q[$];
  int          start_cyc_q[$];
  logic [15:0] start_data_q[$];
  int          rsp_cyc_q[$];
  int          rsp_id_q[$];
  int          rsp_ok_q[$];
  int          last_ready_cyc = 0;
  int          busy_low_cyc = 0;
  logic        busy_prev = 1'b0;

  always @(negedge clk) begin : recorder
    cyc++;
    if (bus.req0_valid && bus.req0_ready) begin grant_q.push_back(0); last_ready_cyc = cyc; end
    if (bus.req1_valid && bus.req1_ready) begin grant_q.push_back(1); last_ready_cyc = cyc; end
    if (bus.m_start) begin start_cyc_q.push_back(cyc); start_data_q.push_back(bus.m_data); end
    if (bus.rsp_valid) begin
      rsp_cyc_q.push_back(cyc); rsp_id_q.push_back(int'(bus.rsp_id)); rsp_ok_q.push_back(int'(bus.rsp_ok));
    end
    if (busy_prev && !bus.busy) busy_low_cyc = cyc;
    busy_prev = bus.busy;
  end

  // ---------------- I2C master responder ----------------
  int resp_delay = 3;
  bit resp_nack  = 1'b0;
  bit resp_never = 1'b0;

  initial begin : responder
    bus.m_done = 1'b0;
    bus.m_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.m_start === 1'b1 && !resp_never) begin
        repeat (resp_delay) @(posedge clk);
        #1;
        bus.m_done = 1'b1; bus.m_nack = resp_nack;
        @(posedge clk);
        #1;
        bus.m_done = 1'b0; bus.m_nack = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int port, input logic [15:0] w);
    int   k;
    logic rdy;
    k = 0;
    if (port == 0) begin bus.req0_valid = 1'b1; bus.req0_data = w; end
    else           begin bus.req1_valid = 1'b1; bus.req1_data = w; end
    forever begin
      @(negedge clk);
      rdy = (port == 0) ? bus.req0_ready : bus.req1_ready;
      if (rdy) break;
      k++;
      if (k > 3000) begin chk("grant_wait", 32'(rdy), 32'd1); break; end
    end
    @(posedge clk);
    #1;
    if (port == 0) begin bus.req0_valid = 1'b0; bus.req0_data = 16'hDEAD; end
    else           begin bus.req1_valid = 1'b0; bus.req1_data = 16'hBEEF; end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if (!bus.busy && mdl_idle) break;
      k++;
      if (k > 3000) begin chk("idle_wait", 32'(bus.busy), 32'd0); break; end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #400us;
    $display("FAIL watchdog: actual=running required=finished");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin : stimulus
    int ns, nr, ng;
    bus.req0_valid = 1'b0; bus.req0_data = 16'h0000;
    bus.req1_valid = 1'b0; bus.req1_data = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_start",   32'(bus.m_start),   32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;

    // Single port-0 word, ack 40 cycles after m_start.
    resp_delay = 40; ns = start_cyc_q.size(); nr = rsp_cyc_q.size();
    send(0, 16'h0C00);
    wait_idle();
    chk("t1_start_count",   32'(start_cyc_q.size() - ns), 32'd1);
    chk("t1_ready_to_start", 32'(start_cyc_q[ns] - last_ready_cyc), 32'd1);
    chk("t1_m_data",        32'(start_data_q[ns]), 32'h0C00);
    chk("t1_done_to_rsp",   32'(rsp_cyc_q[nr] - start_cyc_q[ns]), 32'd41);
    chk("t1_rsp_id",        32'(rsp_id_q[nr]), 32'd0);
    chk("t1_rsp_ok",        32'(rsp_ok_q[nr]), 32'd1);
    chk("t1_busy_low",      32'(busy_low_cyc - rsp_cyc_q[nr]), 32'd6);

    // Port 0 streams 10 words while port 1 waits: port 1 is the 5th grant.
    resp_delay = 3; ng = grant_q.size();
    fork
      begin for (int i = 0; i < 10; i++) send(0, 16'(16'h0400 + i)); end
      begin send(1, 16'h0817); end
    join
    wait_idle();
    chk("t3_grants",  32'(grant_q.size() - ng), 32'd11);
    chk("t3_grant4",  32'(grant_q[ng + 3]), 32'd0);
    chk("t3_grant5",  32'(grant_q[ng + 4]), 32'd1);
    chk("t3_grant6",  32'(grant_q[ng + 5]), 32'd0);

    // Both ports on the same cycle with a cleared starve count: A then B.
    ns = start_cyc_q.size(); nr = rsp_cyc_q.size();
    fork
      send(0, 16'h0A5A);
      send(1, 16'h1234);
    join
    wait_idle();
    chk("t2_first_data",  32'(start_data_q[ns]),     32'h0A5A);
    chk("t2_second_data", 32'(start_data_q[ns + 1]), 32'h1234);
    chk("t2_rsp0_id",     32'(rsp_id_q[nr]),         32'd0);
    chk("t2_rsp1_id",     32'(rsp_id_q[nr + 1]),     32'd1);
    chk("t2_gap",         32'(start_cyc_q[ns + 1] - rsp_cyc_q[nr]), 32'd7);

    // NACK on every attempt: three issues of the same word, one failed rsp.
    resp_nack = 1'b1; resp_delay = 5; ns = start_cyc_q.size(); nr = rsp_cyc_q.size();
    send(0, 16'h1E00);
    wait_idle();
    resp_nack = 1'b0;
    chk("t4_starts",   32'(start_cyc_q.size() - ns), 32'd3);
    chk("t4_space1",   32'(start_cyc_q[ns + 1] - start_cyc_q[ns]), 32'd11);
    chk("t4_space2",   32'(start_cyc_q[ns + 2] - start_cyc_q[ns + 1]), 32'd11);
    chk("t4_data2",    32'(start_data_q[ns + 1]), 32'h1E00);
    chk("t4_data3",    32'(start_data_q[ns + 2]), 32'h1E00);
    chk("t4_rsps",     32'(rsp_cyc_q.size() - nr), 32'd1);
    chk("t4_rsp_ok",   32'(rsp_ok_q[nr]), 32'd0);

    // No completion at all: three 50-cycle timeouts, then a failed rsp.
    resp_never = 1'b1; ns = start_cyc_q.size(); nr = rsp_cyc_q.size();
    send(1, 16'h0A17);
    wait_idle();
    resp_never = 1'b0;
    chk("t5_starts",   32'(start_cyc_q.size() - ns), 32'd3);
    chk("t5_space",    32'(start_cyc_q[ns + 1] - start_cyc_q[ns]), 32'd56);
    chk("t5_rsp_lat",  32'(rsp_cyc_q[nr] - start_cyc_q[ns + 2]), 32'd51);
    chk("t5_rsp_id",   32'(rsp_id_q[nr]), 32'd1);
    chk("t5_rsp_ok",   32'(rsp_ok_q[nr]), 32'd0);

    // Completion in the 50th WAIT cycle beats the timeout.
    resp_delay = 50; ns = start_cyc_q.size(); nr = rsp_cyc_q.size();
    send(0, 16'h0817);
    wait_idle();
    chk("t5b_starts",  32'(start_cyc_q.size() - ns), 32'd1);
    chk("t5b_rsp_lat", 32'(rsp_cyc_q[nr] - start_cyc_q[ns]), 32'd51);
    chk("t5b_rsp_ok",  32'(rsp_ok_q[nr]), 32'd1);

    // Reset in WAIT clears outputs at once; next word is served cleanly.
    resp_never = 1'b1; resp_delay = 3; nr = rsp_cyc_q.size();
    send(0, 16'h0C1F);
    repeat (10) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("t6_m_start", 32'(bus.m_start),   32'd0);
    chk("t6_busy",    32'(bus.busy),      32'd0);
    chk("t6_m_data",  32'(bus.m_data),    32'h0000);
    chk("t6_rsp",     32'(bus.rsp_valid), 32'd0);
    bus.req0_valid = 1'b1; bus.req0_data = 16'h0E55;
    #1;
    chk("t6_ready_in_reset", 32'(bus.req0_ready), 32'd0);
    resp_never = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    ns = start_cyc_q.size();
    send(0, 16'h0E55);
    wait_idle();
    chk("t6_rsps",    32'(rsp_cyc_q.size() - nr), 32'd1);
    chk("t6_data",    32'(start_data_q[ns]), 32'h0E55);
    chk("t6_rsp_ok",  32'(rsp_ok_q[nr]), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
